reg_file: RTL and testbench



---
 rtl/mips_pkg.sv | 9 +
 rtl/reg_scoreboard.sv | 73 +++++++
 rtl/reg_file.sv | 74 +++++++
 tb/tb_reg_file.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared datapath widths and register-address type for the integer pipeline.
package mips_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating in-flight-writer counter per
// architectural register, plus source-pending flags and the issue hold signal.
module reg_scoreboard #(
   parameter int NREGS = 32,
   parameter int CNT_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reg_write,
   input  mips_pkg::reg_addr_t write_register,
   input  mips_pkg::reg_addr_t read_register_1,
   input  mips_pkg::reg_addr_t read_register_2,
   input  logic                issue_valid,
   input  logic                issue_reg_write,
   input  mips_pkg::reg_addr_t issue_dest,
   output logic                src_pending_1,
   output logic                src_pending_2,
   output logic                issue_ready
);
   import mips_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_reg [NREGS];
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] dest_cnt;
   logic [CNT_W-1:0] rd1_cnt;
   logic [CNT_W-1:0] rd2_cnt;
   logic             inc;
   logic             dec;
   logic             dec_on_dest;

   always_comb begin
      wr_cnt      = cnt_reg[write_register];
      dest_cnt    = cnt_reg[issue_dest];
      rd1_cnt     = cnt_reg[read_register_1];
      rd2_cnt     = cnt_reg[read_register_2];

      dec         = reg_write && (write_register != REG_ZERO) && (wr_cnt != '0);
      dec_on_dest = dec && (write_register == issue_dest);
      // A retiring writer in the same cycle frees a slot, so a full counter can still accept.
      issue_ready = !(issue_reg_write && (issue_dest != REG_ZERO) &&
                      (dest_cnt == CNT_MAX) && !dec_on_dest);
      inc         = issue_valid && issue_reg_write && issue_ready && (issue_dest != REG_ZERO);

      // The last outstanding writer landing this cycle is covered by the read bypass.
      src_pending_1 = (read_register_1 != REG_ZERO) && (rd1_cnt != '0) &&
                      !((rd1_cnt == CNT_ONE) && reg_write && (write_register == read_register_1));
      src_pending_2 = (read_register_2 != REG_ZERO) && (rd2_cnt != '0) &&
                      !((rd2_cnt == CNT_ONE) && reg_write && (write_register == read_register_2));
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
         logic inc_hit;
         logic dec_hit;

         assign inc_hit = inc && (issue_dest == reg_addr_t'(gi));
         assign dec_hit = dec && (write_register == reg_addr_t'(gi));

         always_ff @(posedge clk) begin
            if (rst || (gi == 0)) begin
               cnt_reg[gi] <= '0;
            end else if (inc_hit && !dec_hit) begin
               cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
            end else if (dec_hit && !inc_hit) begin
               cnt_reg[gi] <= cnt_reg[gi] - CNT_ONE;
            end
         end
      end
   endgenerate
endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit general register file with write-through bypass on both read
// ports and a pending-write scoreboard for decode-stage hazard stalls.
module reg_file #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int NREGS  = 32,
   parameter int CNT_W  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reg_write,
   input  mips_pkg::reg_addr_t write_register,
   input  logic [DATA_W-1:0]   write_data_reg,
   input  mips_pkg::reg_addr_t read_register_1,
   input  mips_pkg::reg_addr_t read_register_2,
   output logic [DATA_W-1:0]   read_data_1,
   output logic [DATA_W-1:0]   read_data_2,
   input  logic                issue_valid,
   input  logic                issue_reg_write,
   input  mips_pkg::reg_addr_t issue_dest,
   output logic                src_pending_1,
   output logic                src_pending_2,
   output logic                issue_ready
);
   import mips_pkg::*;

   logic [DATA_W-1:0] mem_reg [NREGS];

   // Register 0 is kept at zero in storage as well as on the read path.
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_mem
         always_ff @(posedge clk) begin
            if (rst || (gi == 0)) begin
               mem_reg[gi] <= '0;
            end else if (reg_write && (write_register == reg_addr_t'(gi))) begin
               mem_reg[gi] <= write_data_reg;
            end
         end
      end
   endgenerate

   always_comb begin
      read_data_1 = mem_reg[read_register_1];
      if (read_register_1 == REG_ZERO) begin
         read_data_1 = '0;
      end else if (reg_write && (write_register == read_register_1)) begin
         read_data_1 = write_data_reg;
      end

      read_data_2 = mem_reg[read_register_2];
      if (read_register_2 == REG_ZERO) begin
         read_data_2 = '0;
      end else if (reg_write && (write_register == read_register_2)) begin
         read_data_2 = write_data_reg;
      end
   end

   reg_scoreboard #(
      .NREGS (NREGS),
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk             (clk),
      .rst             (rst),
      .reg_write       (reg_write),
      .write_register  (write_register),
      .read_register_1 (read_register_1),
      .read_register_2 (read_register_2),
      .issue_valid     (issue_valid),
      .issue_reg_write (issue_reg_write),
      .issue_dest      (issue_dest),
      .src_pending_1   (src_pending_1),
      .src_pending_2   (src_pending_2),
      .issue_ready     (issue_ready)
   );
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_reg_file;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reg_write = 1'b0;
   logic [4:0]  write_register = '0;
   logic [31:0] write_data_reg = '0;
   logic [4:0]  read_register_1 = '0;
   logic [4:0]  read_register_2 = '0;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;
   logic        issue_valid = 1'b0;
   logic        issue_reg_write = 1'b0;
   logic [4:0]  issue_dest = '0;
   logic        src_pending_1;
   logic        src_pending_2;
   logic        issue_ready;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model: register contents and in-flight writer counts.
   logic [31:0] m_mem [32];
   int          m_cnt [32];

   always #5 clk = ~clk;

   reg_file dut (
      .clk             (clk),
      .rst             (rst),
      .reg_write       (reg_write),
      .write_register  (write_register),
      .write_data_reg  (write_data_reg),
      .read_register_1 (read_register_1),
      .read_register_2 (read_register_2),
      .read_data_1     (read_data_1),
      .read_data_2     (read_data_2),
      .issue_valid     (issue_valid),
      .issue_reg_write (issue_reg_write),
      .issue_dest      (issue_dest),
      .src_pending_1   (src_pending_1),
      .src_pending_2   (src_pending_2),
      .issue_ready     (issue_ready)
   );

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (reg_write && write_register == a) return write_data_reg;
      return m_mem[a];
   endfunction

   function automatic logic m_pending(input logic [4:0] a);
      if (a == 0 || m_cnt[a] == 0) return 1'b0;
      if (m_cnt[a] == 1 && reg_write && write_register == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_ready();
      bit retiring;
      retiring = reg_write && write_register == issue_dest && m_cnt[issue_dest] > 0;
      return !(issue_reg_write && issue_dest != 0 && m_cnt[issue_dest] == 3 && !retiring);
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_cnt[i] = 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
         end
      end else begin
         bit inc, dec;
         inc = issue_valid && issue_reg_write && m_ready() && issue_dest != 0;
         dec = reg_write && write_register != 0 && m_cnt[write_register] > 0;
         if (inc) m_cnt[issue_dest] = m_cnt[issue_dest] + 1;
         if (dec) m_cnt[write_register] = m_cnt[write_register] - 1;
         if (reg_write && write_register != 0) m_mem[write_register] = write_data_reg;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every negedge, all outputs against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("model_rd1", read_data_1, m_read(read_register_1));
         check("model_rd2", read_data_2, m_read(read_register_2));
         check("model_pend1", {31'b0, src_pending_1}, {31'b0, m_pending(read_register_1)});
         check("model_pend2", {31'b0, src_pending_2}, {31'b0, m_pending(read_register_2)});
         check("model_ready", {31'b0, issue_ready}, {31'b0, m_ready()});
      end
   end

   task automatic drive(input logic r, input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic iv, input logic irw, input logic [4:0] id);
      @(posedge clk);
      #1;
      rst = r; reg_write = rw; write_register = wr; write_data_reg = wd;
      read_register_1 = r1; read_register_2 = r2;
      issue_valid = iv; issue_reg_write = irw; issue_dest = id;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic issue9_expect(input logic exp_ready, input string name);
      drive(0, 0, 0, 0, 0, 9, 1, 1, 9); settle();
      check(name, {31'b0, issue_ready}, {31'b0, exp_ready});
      $display("issue dest=9 ready=%0b", issue_ready);
   endtask

   initial begin
      // Reset and idle reads
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1; chk_en = 1'b1;
      drive(0, 0, 0, 0, 5, 31, 0, 0, 0); settle();
      check("rst_rd_r5", read_data_1, 32'h0);
      check("rst_rd_r31", read_data_2, 32'h0);
      check("rst_pend", {30'b0, src_pending_1, src_pending_2}, 32'h0);
      check("rst_ready", {31'b0, issue_ready}, 32'h1);
      $display("reset: rd5=0x%08h rd31=0x%08h ready=%0b", read_data_1, read_data_2, issue_ready);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
      check("rst_rd_r0", read_data_1, 32'h0);

      // Write-through bypass and register 0
      drive(0, 1, 8, 32'hDEADBEEF, 8, 0, 0, 0, 0); settle();
      check("bypass_r8", read_data_1, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 8, 0, 0, 0, 0); settle();
      check("stored_r8", read_data_1, 32'hDEADBEEF);
      $display("write r8: rd1=0x%08h", read_data_1);
      drive(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0); settle();
      check("r0_bypass", read_data_1, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
      check("r0_stored", read_data_1, 32'h0);
      $display("write r0: rd=0x%08h", read_data_1);

      // Counter saturation at 3
      issue9_expect(1'b1, "issue9_1");
      issue9_expect(1'b1, "issue9_2");
      issue9_expect(1'b1, "issue9_3");
      issue9_expect(1'b0, "issue9_full");
      drive(0, 1, 9, 32'h9, 0, 9, 1, 1, 9); settle();
      check("issue9_with_wb", {31'b0, issue_ready}, 32'h1);
      check("pend9_cnt3_wb", {31'b0, src_pending_2}, 32'h1);
      $display("issue+wb r9: ready=%0b", issue_ready);
      issue9_expect(1'b0, "issue9_still_full");

      // Drain r9 to a single writer, then resolve through the bypass
      drive(0, 1, 9, 32'h1, 0, 0, 0, 0, 0);
      drive(0, 1, 9, 32'h2, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
      check("pend9_cnt1", {31'b0, src_pending_2}, 32'h1);
      drive(0, 1, 9, 32'h55, 0, 9, 0, 0, 0); settle();
      check("pend9_wb", {31'b0, src_pending_2}, 32'h0);
      check("rd9_wb", read_data_2, 32'h55);
      drive(0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
      check("pend9_clear", {31'b0, src_pending_2}, 32'h0);
      check("rd9_stored", read_data_2, 32'h55);
      $display("wb r9: rd2=0x%08h pend2=%0b", read_data_2, src_pending_2);

      // Simultaneous inc/dec on r12, writeback to idle r13
      drive(0, 0, 0, 0, 0, 0, 1, 1, 12);
      drive(0, 1, 12, 32'hC, 12, 0, 1, 1, 12); settle();
      check("pend12_incdec", {31'b0, src_pending_1}, 32'h0);
      drive(0, 0, 0, 0, 12, 0, 0, 0, 0); settle();
      check("pend12_cnt1", {31'b0, src_pending_1}, 32'h1);
      drive(0, 1, 13, 32'hABC, 0, 13, 0, 0, 0); settle();
      check("rd13_bypass", read_data_2, 32'hABC);
      drive(0, 0, 0, 0, 0, 13, 0, 0, 0); settle();
      check("rd13_stored", read_data_2, 32'hABC);
      check("pend13_zero", {31'b0, src_pending_2}, 32'h0);
      $display("r12/r13: pend1=%0b rd13=0x%08h", src_pending_1, read_data_2);

      // Reset beats a concurrent write and issue
      drive(1, 1, 4, 32'h77, 0, 0, 1, 1, 4);
      drive(0, 0, 0, 0, 4, 8, 0, 0, 0); settle();
      check("rst_r4", read_data_1, 32'h0);
      check("rst_pend4", {31'b0, src_pending_1}, 32'h0);
      check("rst_r8", read_data_2, 32'h0);
      $display("reset race: rd4=0x%08h pend4=%0b", read_data_1, src_pending_1);

      // Randomized traffic on a narrow address window to force collisions
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] a_wr, a_r1, a_r2, a_id;
         a_wr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
         a_r1 = 5'($urandom_range(0, 6));
         a_r2 = ($urandom_range(0, 3) == 0) ? a_wr : 5'($urandom_range(0, 6));
         a_id = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
         drive(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), a_wr, $urandom,
               a_r1, a_r2, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), a_id);
         if (i % 500 == 0)
            $display("random cycle %0d: checks=%0d", i, n_checks);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
